// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter feeding one SDRAM controller (single write word or read burst).
// Latency: eligible request to controller command in 1 cycle; done/rvalid registered, 1 cycle after controller strobe.
// Backpressure: a port holds req until done; losing or busy ports simply wait, no requests are dropped.
module sdram_arbiter #(
  parameter int ADDR_WIDTH        = 22,
  parameter int DATA_WIDTH        = 16,
  parameter int READ_BURST_LENGTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] address,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rvalid,
  output logic [1:0]              ctrl_command,
  output logic [ADDR_WIDTH-1:0]   ctrl_address,
  output logic [DATA_WIDTH-1:0]   ctrl_wdata,
  input  logic [DATA_WIDTH-1:0]   ctrl_rdata,
  input  logic                    ctrl_read_valid,
  input  logic                    ctrl_write_done
);

  localparam int BW = $clog2(READ_BURST_LENGTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(READ_BURST_LENGTH - 1);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    grant_q;   // current grant while busy, last grant while idle
  logic [BW-1:0]           beat_q;
  logic [1:0]              done_q;
  logic [1:0]              rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              cmd_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  // A port that just got its done pulse sits out one cycle, which also guarantees the idle gap.
  logic [1:0] elig;
  logic       sel_d;
  assign elig  = req & ~done_q;
  assign sel_d = (&elig) ? ~grant_q : elig[1];

  // Arbitration, command issue and transaction tracking in one registered FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      beat_q   <= '0;
      done_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      cmd_q    <= CMD_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      done_q   <= '0;
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          cmd_q <= CMD_IDLE;
          if (|elig) begin
            grant_q <= sel_d;
            addr_q  <= sel_d ? address[2*ADDR_WIDTH-1:ADDR_WIDTH] : address[ADDR_WIDTH-1:0];
            wdata_q <= sel_d ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
            if (we[sel_d]) begin
              cmd_q   <= CMD_WRITE;
              state_q <= WRITE;
            end else begin
              cmd_q   <= CMD_READ;
              state_q <= READ;
            end
          end
        end
        WRITE: begin
          if (ctrl_write_done) begin
            cmd_q           <= CMD_IDLE;
            done_q[grant_q] <= 1'b1;
            state_q         <= IDLE;
          end
        end
        READ: begin
          if (ctrl_read_valid) begin
            rdata_q           <= ctrl_rdata;
            rvalid_q[grant_q] <= 1'b1;
            if (beat_q == LAST_BEAT) begin
              beat_q          <= '0;
              cmd_q           <= CMD_IDLE;
              done_q[grant_q] <= 1'b1;
              state_q         <= IDLE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: begin
          cmd_q   <= CMD_IDLE;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign ctrl_command = cmd_q;
  assign ctrl_address = addr_q;
  assign ctrl_wdata   = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table plus round-robin and reset-mid-read sequences.
module tb_sdram_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, we;
  logic [2*AW-1:0] address;
  logic [2*DW-1:0] wdata;
  logic [1:0]    done, rvalid, ctrl_command;
  logic [DW-1:0] rdata, ctrl_wdata, ctrl_rdata;
  logic [AW-1:0] ctrl_address;
  logic          ctrl_read_valid, ctrl_write_done;

  int checks = 0;
  int failures = 0;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_BURST_LENGTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wdata(wdata),
    .done(done), .rdata(rdata), .rvalid(rvalid), .ctrl_command(ctrl_command),
    .ctrl_address(ctrl_address), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
    .ctrl_read_valid(ctrl_read_valid), .ctrl_write_done(ctrl_write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [1:0]    req, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rv, wd;
    logic [DW-1:0] crd;
    logic [1:0]    e_cmd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_done, e_rvalid;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic [1:0] rq, logic [1:0] w,
                              logic [AW-1:0] a0, logic [DW-1:0] d0, logic rv, logic wd,
                              logic [DW-1:0] crd, logic [1:0] ecmd, logic [AW-1:0] eaddr,
                              logic [DW-1:0] ewd, logic [1:0] edone, logic [1:0] erv,
                              logic [DW-1:0] erd);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.a0 = a0; v.a1 = 22'h04B000;
    v.d0 = d0; v.d1 = 16'h7777; v.rv = rv; v.wd = wd; v.crd = crd;
    v.e_cmd = ecmd; v.e_addr = eaddr; v.e_wdata = ewd; v.e_done = edone;
    v.e_rvalid = erv; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00; address = '0; wdata = '0;
    ctrl_rdata = '0; ctrl_read_valid = 1'b0; ctrl_write_done = 1'b0;
  endtask

  initial begin
    int n;
    int exp_port;
    logic [AW-1:0] a_p0, a_p1;

    reset = 1'b1;
    idle_inputs();

    // Single write on port 0, spurious read_valid, then port 1 read burst with a stall cycle.
    vq.push_back(mk(1, 2'b00, 2'b00, 22'h0,      16'h0,    0, 0, 16'h0,    0, 22'h0,      16'h0,    2'b00, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b01, 2'b01, 22'h000123, 16'hBEEF, 0, 0, 16'h0,    1, 22'h000123, 16'hBEEF, 2'b00, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b00, 2'b00, 22'h0003FF, 16'h1111, 0, 0, 16'h0,    1, 22'h000123, 16'hBEEF, 2'b00, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b00, 2'b00, 22'h0003FF, 16'h1111, 1, 0, 16'h5555, 1, 22'h000123, 16'hBEEF, 2'b00, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b00, 2'b00, 22'h0003FF, 16'h1111, 0, 1, 16'h0,    0, 22'h000123, 16'hBEEF, 2'b01, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b00, 2'b00, 22'h0003FF, 16'h1111, 0, 0, 16'h0,    0, 22'h000123, 16'hBEEF, 2'b00, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b10, 2'b00, 22'h0003FF, 16'h1111, 0, 0, 16'h0,    2, 22'h04B000, 16'h7777, 2'b00, 2'b00, 16'h0));
    vq.push_back(mk(0, 2'b00, 2'b00, 22'h0003FF, 16'h1111, 0, 1, 16'h0,    2, 22'h04B000, 16'h7777, 2'b00, 2'b00, 16'h0));
    for (int k = 0; k < 8; k++) begin
      vq.push_back(mk(0, 2'b00, 2'b00, 22'h0, 16'h0, 1, 0, 16'(k),
                      (k == 7) ? 2'd0 : 2'd2, 22'h04B000, 16'h7777,
                      (k == 7) ? 2'b10 : 2'b00, 2'b10, 16'(k)));
      if (k == 2)
        vq.push_back(mk(0, 2'b00, 2'b00, 22'h0, 16'h0, 0, 0, 16'h00EE,
                        2, 22'h04B000, 16'h7777, 2'b00, 2'b00, 16'h0002));
    end
    vq.push_back(mk(0, 2'b00, 2'b00, 22'h0, 16'h0, 0, 0, 16'h0, 0, 22'h04B000, 16'h7777, 2'b00, 2'b00, 16'h0007));

    foreach (vq[i]) begin
      reset = vq[i].rst; req = vq[i].req; we = vq[i].we;
      address = {vq[i].a1, vq[i].a0}; wdata = {vq[i].d1, vq[i].d0};
      ctrl_read_valid = vq[i].rv; ctrl_write_done = vq[i].wd; ctrl_rdata = vq[i].crd;
      step();
      chk($sformatf("v%0d.cmd", i),    32'(ctrl_command), 32'(vq[i].e_cmd));
      chk($sformatf("v%0d.addr", i),   32'(ctrl_address), 32'(vq[i].e_addr));
      chk($sformatf("v%0d.wdata", i),  32'(ctrl_wdata),   32'(vq[i].e_wdata));
      chk($sformatf("v%0d.done", i),   32'(done),         32'(vq[i].e_done));
      chk($sformatf("v%0d.rvalid", i), 32'(rvalid),       32'(vq[i].e_rvalid));
      chk($sformatf("v%0d.rdata", i),  32'(rdata),        32'(vq[i].e_rdata));
    end

    // Round-robin: both ports write continuously from reset; expect grants 0,1,0,1.
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    a_p0 = 22'h000010;
    a_p1 = 22'h000020;
    reset = 1'b0; req = 2'b11; we = 2'b11;
    address = {a_p1, a_p0}; wdata = {16'h2222, 16'h1111};
    for (int t = 0; t < 4; t++) begin
      exp_port = t % 2;
      n = 0;
      while (ctrl_command == 2'd0 && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d.wait_cycles", t), 32'(n), 32'd1);
      chk($sformatf("rr%0d.cmd", t), 32'(ctrl_command), 32'd1);
      chk($sformatf("rr%0d.addr", t), 32'(ctrl_address), 32'((exp_port == 0) ? a_p0 : a_p1));
      ctrl_write_done = 1'b1;
      step();
      ctrl_write_done = 1'b0;
      chk($sformatf("rr%0d.done", t), 32'(done), 32'((exp_port == 0) ? 2'b01 : 2'b10));
      chk($sformatf("rr%0d.cmd_gap", t), 32'(ctrl_command), 32'd0);
    end

    // Reset mid-read on port 0 after 3 beats; afterwards port 0 must win the tie again.
    idle_inputs();
    step();
    step();
    req = 2'b01; we = 2'b00; address = {22'h000300, 22'h000200};
    step();
    chk("mr.cmd_read", 32'(ctrl_command), 32'd2);
    req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      ctrl_read_valid = 1'b1; ctrl_rdata = 16'(16'hA0 + k);
      step();
      chk($sformatf("mr.beat%0d.rvalid", k), 32'(rvalid), 32'b01);
      chk($sformatf("mr.beat%0d.rdata", k), 32'(rdata), 32'(16'hA0 + k));
    end
    reset = 1'b1; ctrl_read_valid = 1'b1; ctrl_rdata = 16'hDEAD;
    step();
    ctrl_read_valid = 1'b0;
    chk("mr.rst.cmd", 32'(ctrl_command), 32'd0);
    chk("mr.rst.rvalid", 32'(rvalid), 32'd0);
    chk("mr.rst.done", 32'(done), 32'd0);
    chk("mr.rst.rdata", 32'(rdata), 32'd0);
    reset = 1'b0; req = 2'b11; we = 2'b00;
    step();
    chk("mr.regrant.cmd", 32'(ctrl_command), 32'd2);
    chk("mr.regrant.addr", 32'(ctrl_address), 32'h000200);
    req = 2'b00;
    for (int k = 0; k < 8; k++) begin
      ctrl_read_valid = 1'b1; ctrl_rdata = 16'(16'hC0 + k);
      step();
      chk($sformatf("mr.full%0d.rvalid", k), 32'(rvalid), 32'b01);
      chk($sformatf("mr.full%0d.done", k), 32'(done), 32'((k == 7) ? 2'b01 : 2'b00));
    end
    ctrl_read_valid = 1'b0;
    step();
    chk("mr.end.cmd", 32'(ctrl_command), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 22: SDRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 16: SDRAM data word width.
REQ-003 Parameter READ_BURST_LENGTH, default 8, legal 1..256: words returned per read transaction; it SHALL match the controller's read burst setting.
REQ-004 Port clk, input, 1: single clock, the SDRAM clock domain; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Port req, input, 2: per-requester transaction request; bit i belongs to port i.
REQ-007 Port we, input, 2: per-port direction, 1 = write one word, 0 = read burst; valid while req[i] is high.
REQ-008 Port address, input, 2*ADDR_WIDTH: per-port start address; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port wdata, input, 2*DATA_WIDTH: per-port write word, sliced the same way.
REQ-010 Port done, output, 2: one-cycle pulse per port marking transaction completion.
REQ-011 Port rdata, output, DATA_WIDTH: shared registered read word.
REQ-012 Port rvalid, output, 2: per-port qualifier for rdata.
REQ-013 Port ctrl_command, output, 2: controller command; 0 = idle, 1 = write, 2 = read.
REQ-014 Port ctrl_address, output, ADDR_WIDTH: controller data_address.
REQ-015 Port ctrl_wdata, output, DATA_WIDTH: controller data_write.
REQ-016 Port ctrl_rdata, input, DATA_WIDTH: controller data_read.
REQ-017 Port ctrl_read_valid, input, 1: controller data_read_valid.
REQ-018 Port ctrl_write_done, input, 1: controller data_write_done.

Function
REQ-019 The state machine SHALL have three states:
- IDLE
- WRITE
- READ
REQ-020 In IDLE, ctrl_command SHALL be 0.
REQ-021 A port is eligible in a given cycle when req[i]=1 and done[i]=0.
REQ-022 Arbitration in IDLE SHALL be round-robin:
- if both ports are eligible, grant the port not granted last;
- if only one is eligible, grant that port.
REQ-023 On grant, at the next edge:
- latch address, wdata and we for the granted port into ctrl_address, ctrl_wdata and the grant index;
- set ctrl_command to 1 (we=1) or 2 (we=0);
- enter WRITE or READ respectively.
The latency from an eligible request to a nonzero command SHALL be 1 cycle.
REQ-024 ctrl_address, ctrl_wdata and ctrl_command SHALL stay constant for the whole transaction, regardless of changes on req, we, address or wdata.
REQ-025 In WRITE, when ctrl_write_done=1, the next edge SHALL:
- set ctrl_command to 0;
- pulse done[grant] for 1 cycle;
- return to IDLE.
REQ-026 In READ, each cycle with ctrl_read_valid=1 SHALL, at the next edge:
- register ctrl_rdata into rdata;
- pulse rvalid[grant] for 1 cycle;
- increment the beat counter, which has width clog2(READ_BURST_LENGTH+1).
REQ-027 On the READ_BURST_LENGTH-th beat, the same edge SHALL:
- set ctrl_command to 0;
- pulse done[grant] coincident with the final rvalid;
- clear the beat counter;
- return to IDLE.
REQ-028 Every transaction SHALL be followed by at least 1 cycle with ctrl_command=0 before the next command.
REQ-029 ctrl_write_done SHALL be ignored outside WRITE, and ctrl_read_valid SHALL be ignored outside READ.
REQ-030 Deasserting req mid-transaction SHALL NOT abort the transaction; done SHALL still pulse.
REQ-031 A port still holding req after its done pulse SHALL be eligible again from the following cycle, subject to round-robin.
REQ-032 rvalid and done SHALL never be asserted for the non-granted port.

Reset
REQ-033 While reset is high, at each edge:
- state = IDLE;
- ctrl_command = 0;
- ctrl_address = 0;
- ctrl_wdata = 0;
- rdata = 0;
- rvalid = 0;
- done = 0;
- beat counter = 0;
- last-grant pointer = port 1, so port 0 wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction:
- no done pulse for it;
- ctrl_command = 0 at the edge following reset.

Verification
REQ-035 Single write: port 0 requests we=1, address=0x000123, wdata=0xBEEF. Required: ctrl_command=1 with address 0x000123 and data 0xBEEF one cycle later; ctrl_write_done pulse -> ctrl_command=0 and done=2'b01 at the next edge.
REQ-036 Read burst: port 1 requests we=0, address=0x04B000, with READ_BURST_LENGTH=8. The controller returns 0x0000..0x0007. Required: eight rvalid=2'b10 pulses with matching rdata; done=2'b10 coincident with the 8th pulse; ctrl_command=0 after the burst.
REQ-037 Tie and round-robin: both ports request continuously from reset. Required grant order 0, 1, 0, 1, with at least one ctrl_command=0 cycle between transactions.
REQ-038 Spurious inputs: ctrl_read_valid during WRITE and ctrl_write_done during READ. Required: no rvalid, done or state change caused by them.
REQ-039 Reset mid-read: reset is asserted after the 3rd beat of a burst. Required: ctrl_command=0, rvalid=0, done=0; the next grant after reset goes to port 0 when both ports request.
